// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory-controller port between instruction fetch (I)
// and load/store (D), with a bounded D streak and a hung-access timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic              grant_d
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TIMER_W  = 8;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [TIMER_W-1:0]  timer;

  logic d_pend;
  logic in_grant;
  logic timeout_hit;
  logic done;
  logic d_wins;

  assign d_pend      = d_read | d_write;
  assign in_grant    = (state == GRANT_I) || (state == GRANT_D);
  assign timeout_hit = in_grant && (timer == TIMER_W'(TIMEOUT - 1)) && !mem_ready;
  assign done        = in_grant && (mem_ready || timeout_hit);
  // D is the older instruction, but yields once the streak limit is reached.
  assign d_wins      = d_pend && (!i_req || (streak < STREAK_W'(MAX_D_STREAK)));

  // Completion is returned combinationally in the cycle mem_ready (or the timeout) occurs.
  assign i_ready = (state == GRANT_I) && done;
  assign d_ready = (state == GRANT_D) && done;
  assign i_rdata = ((state == GRANT_I) && !timeout_hit) ? mem_rdata : '0;
  assign d_rdata = ((state == GRANT_D) && !timeout_hit) ? mem_rdata : '0;
  assign bus_err = timeout_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      timer     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_d   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wins) begin
            state     <= GRANT_D;
            grant_d   <= 1'b1;
            mem_write <= d_write;
            mem_read  <= d_read & ~d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            timer     <= '0;
            if (!i_req)
              streak <= '0;
            else if (streak < STREAK_W'(MAX_D_STREAK))
              streak <= streak + 1'b1;
          end else if (i_req) begin
            state     <= GRANT_I;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            timer     <= '0;
            streak    <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (done) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            grant_d   <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle vector table plus
// directed sequences for streak fairness, timeout and mid-access reset.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err, grant_d;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err), .grant_d(grant_d)
  );

  always #5 clock = ~clock;

  // One record per cycle: inputs driven for that cycle, outputs expected in it.
  typedef struct {
    logic [31:0] i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata;
    logic [31:0] e_rd, e_wr, e_gd, e_chk, e_addr, e_wdata, e_ir, e_dr, e_irdata, e_drdata, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Withholds mem_ready on a D read; optionally returns it exactly in the limit cycle.
  task automatic run_timeout(input bit ready_at_limit, input string tag);
    int  k = 0;
    bit  hit = 0;
    d_read = 1'b1; d_addr = 32'h300; mem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 120 && !hit; c++) begin
      tick();
      if (mem_read) k++;
      mem_ready = ready_at_limit && (k == 64);
      #1;
      if (d_ready || bus_err) begin
        hit = 1;
        chk({tag, "_cycle"}, 32'(k), 32'd64);
        chk({tag, "_bus_err"}, 32'(bus_err), ready_at_limit ? 32'd0 : 32'd1);
        chk({tag, "_d_ready"}, 32'(d_ready), 32'd1);
        chk({tag, "_d_rdata"}, d_rdata, ready_at_limit ? 32'hBAD0BAD0 : 32'd0);
      end
    end
    if (!hit) chk({tag, "_completion_seen"}, 32'd0, 32'd1);
    tick();
    idle_inputs();
    #1;
    chk({tag, "_done_strobe"}, 32'(mem_read), 32'd0);
    chk({tag, "_done_err"}, 32'(bus_err), 32'd0);
    tick();
    #1;
    chk({tag, "_idle_strobe"}, 32'(mem_read | mem_write), 32'd0);
  endtask

  initial begin
    string got = "";
    int    d_left = 6, i_left = 1;
    bit    d_drop = 0, i_drop = 0;

    reset = 1'b1;
    idle_inputs();
    #2;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_grant_d", 32'(grant_d), 0);
    chk("rst_ready", 32'({i_ready, d_ready, bus_err}), 0);
    tick();
    reset = 1'b0;

    // i_req r_addr dr dw d_addr wdata mrdy mrdata | rd wr gd chk addr wdata ir dr irdata drdata err
    vecs.push_back('{1,'h100,0,0,0,0,0,0,                 0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{1,'h100,0,0,0,0,0,0,                 1,0,0,1,'h100,0,     0,0,0,0,0});
    vecs.push_back('{1,'h100,0,0,0,0,1,'hDEADBEEF,        1,0,0,1,'h100,0,     1,0,'hDEADBEEF,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{1,'h200,0,1,'h40,'h55,0,0,           0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{1,'h200,0,1,'h40,'h55,1,'h1234,      0,1,1,1,'h40,'h55,   0,1,0,'h1234,0});
    vecs.push_back('{1,'h200,0,0,0,0,0,0,                 0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{1,'h200,0,0,0,0,0,0,                 0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{1,'h200,0,0,0,0,1,'hCAFE,            1,0,0,1,'h200,0,     1,0,'hCAFE,0,0});
    vecs.push_back('{0,0,0,0,0,0,1,'h99,                  0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{0,0,1,1,'h80,'h77,0,0,               0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{0,0,1,1,'h80,'h77,1,0,               0,1,1,1,'h80,'h77,   0,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,1,'h99,                  0,0,0,0,0,0,         0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,1,'h99,                  0,0,0,0,0,0,         0,0,0,0,0});

    foreach (vecs[k]) begin
      tick();
      i_req = 1'(vecs[k].i_req);     i_addr = vecs[k].i_addr;
      d_read = 1'(vecs[k].d_read);   d_write = 1'(vecs[k].d_write);
      d_addr = vecs[k].d_addr;       d_wdata = vecs[k].d_wdata;
      mem_ready = 1'(vecs[k].mem_ready); mem_rdata = vecs[k].mem_rdata;
      #1;
      chk($sformatf("v%0d_mem_read", k), 32'(mem_read), vecs[k].e_rd);
      chk($sformatf("v%0d_mem_write", k), 32'(mem_write), vecs[k].e_wr);
      chk($sformatf("v%0d_grant_d", k), 32'(grant_d), vecs[k].e_gd);
      if (vecs[k].e_chk != 0) begin
        chk($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].e_addr);
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      end
      chk($sformatf("v%0d_i_ready", k), 32'(i_ready), vecs[k].e_ir);
      chk($sformatf("v%0d_d_ready", k), 32'(d_ready), vecs[k].e_dr);
      chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].e_irdata);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].e_drdata);
      chk($sformatf("v%0d_bus_err", k), 32'(bus_err), vecs[k].e_err);
    end

    // I held against six D requests with a streak limit of four.
    idle_inputs();
    i_addr = 32'h700; d_addr = 32'h800;
    for (int c = 0; c < 80 && (d_left > 0 || i_left > 0); c++) begin
      tick();
      i_req = (i_left > 0) && !i_drop;
      d_read = (d_left > 0) && !d_drop;
      i_drop = 0; d_drop = 0;
      mem_ready = mem_read | mem_write;
      mem_rdata = 32'h1111;
      #1;
      if (d_ready) begin
        got = {got, "D"}; d_left--; d_drop = 1;
        if (got.len() == 4) chk("streak_at_limit", 32'(dut.streak), 32'd4);
      end
      if (i_ready) begin
        got = {got, "I"}; i_left--; i_drop = 1;
        chk("streak_after_i", 32'(dut.streak), 32'd0);
      end
    end
    checks++;
    if (got != "DDDDIDD") begin
      failures++;
      $display("FAIL grant_order actual=%s required=DDDDIDD", got);
    end
    tick();
    idle_inputs();
    tick();

    run_timeout(1'b0, "timeout");
    run_timeout(1'b1, "ready_at_limit");

    // Reset while D owns the port.
    tick();
    d_write = 1'b1; d_addr = 32'h500; d_wdata = 32'h66;
    tick();
    #1;
    chk("pre_rst_mem_write", 32'(mem_write), 1);
    chk("pre_rst_grant_d", 32'(grant_d), 1);
    chk("pre_rst_mem_addr", mem_addr, 32'h500);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_write", 32'(mem_write), 0);
    chk("mid_rst_grant_d", 32'(grant_d), 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_d_ready", 32'(d_ready), 0);
    tick();
    d_write = 1'b0; i_req = 1'b1; i_addr = 32'h600;
    #1;
    chk("held_rst_strobe", 32'(mem_read | mem_write), 0);
    tick();
    reset = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h600D;
    #1;
    chk("post_rst_mem_read", 32'(mem_read), 1);
    chk("post_rst_mem_addr", mem_addr, 32'h600);
    chk("post_rst_i_ready", 32'(i_ready), 1);
    chk("post_rst_i_rdata", i_rdata, 32'h600D);
    tick();
    idle_inputs();
    #1;
    chk("post_rst_done", 32'(mem_read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cache/memory controller port between the instruction-fetch requester (I) and the load/store requester (D).
- Priority goes to D, because the MEM stage is the older instruction. A streak limit guarantees I forward progress.
- Drives registered read/write strobes to the memory controller and holds them until its ready.
- Returns ready/data to the granted requester. A timeout turns a hung access into a bus error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, max consecutive D grants while I is pending. Legal range 1..15.
- TIMEOUT, 64, cycles without mem_ready before abort. Legal range 2..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- i_req  in  1  instruction read request, level
- i_addr  in  ADDR_W  instruction address
- i_ready  out  1  one-cycle completion pulse to I
- i_rdata  out  DATA_W  instruction data, valid with i_ready
- d_read  in  1  data read request, level
- d_write  in  1  data write request, level
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle completion pulse to D
- d_rdata  out  DATA_W  load data, valid with d_ready
- mem_read  out  1  read strobe to memory controller, registered
- mem_write  out  1  write strobe to memory controller, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_ready  in  1  memory controller completion, one-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- bus_err  out  1  one-cycle pulse on timeout abort
- grant_d  out  1  status: D owns the port, registered

Behaviour:
- Reset (async): state IDLE, streak=0, timer=0.
  - mem_read, mem_write, mem_addr, mem_wdata, grant_d, bus_err all 0.
  - i_ready and d_ready are 0.
  - Reset asserted mid-access drops strobes immediately and no ready is issued. The memory controller is reset by the same signal.
- States:
  - IDLE: requests sampled here only.
  - GRANT_I, GRANT_D: strobe held.
  - DONE: one-cycle turnaround; strobes 0; requests ignored.
- Handshake: a requester holds its request and its address/data stable until its ready pulse, and deasserts the request in the cycle after ready. The arbiter never samples a request in DONE, so the held level is never re-granted.
- Arbitration in IDLE, next-state logic:
  - D pending (d_read|d_write) and (!i_req or streak<MAX_D_STREAK) -> GRANT_D.
    - streak increments if i_req is high, else clears to 0.
  - Else if i_req -> GRANT_I; streak clears to 0.
  - Else stay in IDLE.
- Grant edge latching:
  - Latched at the grant edge: mem_addr and mem_wdata from the winner. For an I grant, mem_wdata is 0.
  - GRANT_I: mem_read=1.
  - GRANT_D: mem_write=d_write, mem_read=d_read & !d_write. Write wins if both are high.
  - grant_d=1 in GRANT_D.
  - Latency: request seen in IDLE at edge t -> strobe high after edge t.
- In GRANT_x:
  - Requester ready = mem_ready | timeout_hit, combinational in the same cycle.
  - Requester rdata = mem_rdata, or 0 on timeout. Non-granted ready is 0 and its rdata is 0.
  - On completion the next state is DONE; strobes and grant_d clear at that edge.
- Timer:
  - Cleared on grant; increments each cycle in GRANT_x without mem_ready.
  - timeout_hit = (timer == TIMEOUT-1) & !mem_ready.
  - On timeout_hit: bus_err=1 that cycle, combinational, coincident with the ready pulse.
  - mem_ready in the same cycle as the limit counts as normal completion with no error.
- DONE -> IDLE unconditionally. Back-to-back accesses therefore take at least 3 cycles each when mem_ready returns in the first strobe cycle.
- mem_ready while IDLE or DONE is ignored; no ready is generated.
- Streak saturates at MAX_D_STREAK. It is never wraps.

Test Plan:
- Single I read (i_req, i_addr=0x100); mem_ready one cycle after the strobe with rdata 0xDEADBEEF -> mem_read high for exactly 2 cycles, mem_addr=0x100, i_ready pulse with i_rdata=0xDEADBEEF, d_ready stays 0.
- Simultaneous i_req and d_write (addr 0x40, data 0x55) -> D granted first: mem_write=1, mem_wdata=0x55, grant_d=1. I is granted on the IDLE following DONE.
- i_req held with 6 back-to-back D requests, MAX_D_STREAK=4 -> sequence D,D,D,D,I,D,D; streak reads 0 after the I grant.
- mem_ready withheld, TIMEOUT=64 -> bus_err and d_ready pulse together 64 cycles after the strobe rises, d_rdata=0; state passes through DONE and IDLE. A mem_ready arriving exactly at cycle 64 gives no bus_err.
- d_read and d_write both high -> mem_write=1, mem_read=0.
- Reset asserted while in GRANT_D -> mem_write, grant_d and mem_addr go to 0 immediately; no d_ready. After release, a pending i_req is granted normally.
